// File: rtl/tile_sequencer.sv
// tile_sequencer: turn scheduler for the brute-force solver tile chain.
// Clears every tile, then hands a one-cycle turn grant to one tile at a time.
// Control moves forward on that tile's pass-forward pulse and back on its
// pass-back pulse. The block ends in DONE (grid solved) or FAIL (search
// exhausted, or the tile went silent). It also keeps a saturating turn counter
// and a sticky protocol-error flag.
//
// Handshake: tile_myturn is a one-cycle grant with no ready. The granted tile
// answers later with a one-cycle pulse on tile_passfwd or tile_passbak at its
// own index. Only pulses seen in WAIT at cur_idx move the sequencer. Any pulse
// at another index, in any state except CLEAR and SETTLE, sets err and is
// otherwise dropped.
module tile_sequencer #(
  parameter int NUM_TILES  = 16,
  parameter int WAIT_LIMIT = 64,
  parameter int IW         = $clog2(NUM_TILES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_TILES-1:0] tile_passfwd,
  input  logic [NUM_TILES-1:0] tile_passbak,
  output logic                 tiles_clear,
  output logic [NUM_TILES-1:0] tile_myturn,
  output logic [IW-1:0]        cur_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic                 err,
  output logic [15:0]          turns,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SETTLE = 3'd2,
    S_GRANT  = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5,
    S_FAIL   = 3'd6
  } state_e;

  // The watchdog only has to count up to WAIT_LIMIT-1 before it trips.
  localparam int WW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WW-1:0] WD_LAST  = WW'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TILES - 1);

  state_e              state_q, state_d;
  logic [IW-1:0]       cur_idx_q, cur_idx_d;
  logic [15:0]         turns_q, turns_d;
  logic                err_q, err_d;
  logic [WW-1:0]       wd_q, wd_d;
  logic [NUM_TILES-1:0] cur_mask;
  logic                fwd_hit, bak_hit, stray;

  // Decode the current tile's bits and flag any stray pass pulse.
  always_comb begin
    cur_mask = {{(NUM_TILES-1){1'b0}}, 1'b1} << cur_idx_q;
    fwd_hit  = tile_passfwd[cur_idx_q];
    bak_hit  = tile_passbak[cur_idx_q];
    stray    = |((tile_passfwd | tile_passbak) & ~cur_mask);
  end

  // Next-state logic. Index arithmetic is guarded, so cur_idx never wraps.
  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    turns_d   = turns_q;
    err_d     = err_q;
    wd_d      = wd_q;

    // Tiles are held in clear during CLEAR and SETTLE, so their pins mean nothing then.
    if (state_q != S_CLEAR && state_q != S_SETTLE && stray) err_d = 1'b1;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d   = S_CLEAR;
          cur_idx_d = '0;
          turns_d   = '0;
          err_d     = 1'b0;
          wd_d      = '0;
        end
      end
      S_CLEAR:  state_d = S_SETTLE;
      S_SETTLE: state_d = S_GRANT;
      S_GRANT: begin
        if (turns_q != 16'hFFFF) turns_d = turns_q + 16'd1;
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bak_hit) begin
          // Both bits at once is a protocol error; back off as the safer choice.
          if (fwd_hit) err_d = 1'b1;
          if (cur_idx_q == '0) begin
            state_d = S_FAIL;
          end else begin
            cur_idx_d = cur_idx_q - 1'b1;
            state_d   = S_GRANT;
          end
        end else if (fwd_hit) begin
          if (cur_idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            cur_idx_d = cur_idx_q + 1'b1;
            state_d   = S_GRANT;
          end
        end else if (WAIT_LIMIT != 0) begin
          if (wd_q == WD_LAST) begin
            err_d   = 1'b1;
            state_d = S_FAIL;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any solve in progress at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cur_idx_q <= '0;
      turns_q   <= '0;
      err_q     <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      turns_q   <= turns_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
    end
  end

  // Moore outputs decoded only from registered state.
  always_comb begin
    tiles_clear = (state_q == S_CLEAR);
    tile_myturn = (state_q == S_GRANT) ? cur_mask : '0;
    busy        = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
    done        = (state_q == S_DONE);
    fail        = (state_q == S_FAIL);
    cur_idx     = cur_idx_q;
    err         = err_q;
    turns       = turns_q;
    state_dbg   = state_q;
  end

endmodule

// File: tb/tb_tile_sequencer.sv
// Bench for tile_sequencer with a 4-tile chain and an 8-cycle watchdog.
// Stub tiles answer 4 cycles after each grant. A table of solve scenarios
// drives the main loop, and hand-written sequences cover start latency,
// start-while-busy, stray pulses and reset in the middle of a solve.
module tb_tile_sequencer;

  localparam int NT = 4;
  localparam int WL = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [NT-1:0] tile_passfwd = '0;
  logic [NT-1:0] tile_passbak = '0;
  logic          tiles_clear;
  logic [NT-1:0] tile_myturn;
  logic [1:0]    cur_idx;
  logic          busy, done, fail, err;
  logic [15:0]   turns;
  logic [2:0]    state_dbg;

  tile_sequencer #(.NUM_TILES(NT), .WAIT_LIMIT(WL)) dut (
    .clock(clock), .reset(reset), .start(start),
    .tile_passfwd(tile_passfwd), .tile_passbak(tile_passbak),
    .tiles_clear(tiles_clear), .tile_myturn(tile_myturn), .cur_idx(cur_idx),
    .busy(busy), .done(done), .fail(fail), .err(err), .turns(turns),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    logic [NT-1:0] bak_first;
    logic [NT-1:0] both_first;
    int            silent;
    logic [15:0]   order;
    int            n_grants;
    logic          exp_done;
    logic          exp_fail;
    logic          exp_err;
    logic [15:0]   exp_turns;
    logic [1:0]    exp_cur;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [15:0] ord(input int a0, input int a1, input int a2,
                                      input int a3, input int a4, input int a5);
    logic [15:0] r;
    r = '0;
    r[1:0]   = 2'(a0);
    r[3:2]   = 2'(a1);
    r[5:4]   = 2'(a2);
    r[7:6]   = 2'(a3);
    r[9:8]   = 2'(a4);
    r[11:10] = 2'(a5);
    return r;
  endfunction

  // ---------------- stub tiles + grant scoreboard ----------------
  logic [1:0]    exp_q[$];
  logic          stub_en = 1'b0;
  logic [NT-1:0] cfg_bak = '0;
  logic [NT-1:0] cfg_both = '0;
  int            cfg_silent = -1;
  int            grant_cnt[NT];
  int            pend = 0;
  int            pend_idx = 0;
  int            pend_kind = 0;
  int            clear_cnt = 0;
  int            last_grant_cyc = 0;
  int            last_pulse_cyc = 0;
  logic [NT-1:0] prev_turn = '0;

  always @(negedge clock) begin
    int t;
    if (tiles_clear) clear_cnt++;
    if (tile_myturn != '0) begin
      check("grant_onehot", 32'($onehot(tile_myturn)), 32'd1);
      check("grant_not_back_to_back", 32'(prev_turn), 32'd0);
    end
    prev_turn = tile_myturn;
    if (stub_en) begin
      tile_passfwd = '0;
      tile_passbak = '0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (pend_kind != 1) tile_passfwd[pend_idx] = 1'b1;
          if (pend_kind != 0) tile_passbak[pend_idx] = 1'b1;
          last_pulse_cyc = cyc;
        end
      end
      if (tile_myturn != '0) begin
        t = 0;
        for (int i = 0; i < NT; i++) if (tile_myturn[i]) t = i;
        last_grant_cyc = cyc;
        grant_cnt[t]++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant_order: got grant to tile %0d expected no grant", t);
        end else begin
          check("grant_order", 32'(t), 32'(exp_q.pop_front()));
        end
        if (cfg_silent != t) begin
          pend     = 4;
          pend_idx = t;
          if (grant_cnt[t] == 1 && cfg_both[t])     pend_kind = 2;
          else if (grant_cnt[t] == 1 && cfg_bak[t]) pend_kind = 1;
          else                                      pend_kind = 0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_myturn"}, 32'(tile_myturn), 32'd0);
    check({tag, "_clear"},  32'(tiles_clear), 32'd0);
    check({tag, "_cur"},    32'(cur_idx),     32'd0);
    check({tag, "_turns"},  32'(turns),       32'd0);
    check({tag, "_err"},    32'(err),         32'd0);
    check({tag, "_busy"},   32'(busy),        32'd0);
    check({tag, "_done"},   32'(done),        32'd0);
    check({tag, "_fail"},   32'(fail),        32'd0);
  endtask

  // ---------------- main test ----------------
  initial begin
    int end_cyc;
    logic [15:0] o;

    vecs[0] = '{bak_first: 4'b0000, both_first: 4'b0000, silent: -1, order: ord(0,1,2,3,0,0),
                n_grants: 4, exp_done: 1, exp_fail: 0, exp_err: 0, exp_turns: 16'd4, exp_cur: 2'd3};
    vecs[1] = '{bak_first: 4'b0100, both_first: 4'b0000, silent: -1, order: ord(0,1,2,1,2,3),
                n_grants: 6, exp_done: 1, exp_fail: 0, exp_err: 0, exp_turns: 16'd6, exp_cur: 2'd3};
    vecs[2] = '{bak_first: 4'b0001, both_first: 4'b0000, silent: -1, order: ord(0,0,0,0,0,0),
                n_grants: 1, exp_done: 0, exp_fail: 1, exp_err: 0, exp_turns: 16'd1, exp_cur: 2'd0};
    vecs[3] = '{bak_first: 4'b0000, both_first: 4'b0010, silent: -1, order: ord(0,1,0,1,2,3),
                n_grants: 6, exp_done: 1, exp_fail: 0, exp_err: 1, exp_turns: 16'd6, exp_cur: 2'd3};
    vecs[4] = '{bak_first: 4'b0000, both_first: 4'b0000, silent: 2,  order: ord(0,1,2,0,0,0),
                n_grants: 3, exp_done: 0, exp_fail: 1, exp_err: 1, exp_turns: 16'd3, exp_cur: 2'd2};
    vecs[5] = '{bak_first: 4'b1000, both_first: 4'b0000, silent: -1, order: ord(0,1,2,3,2,3),
                n_grants: 6, exp_done: 1, exp_fail: 0, exp_err: 0, exp_turns: 16'd6, exp_cur: 2'd3};

    // Reset state.
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();
    check_all_zero("idle_after_reset");

    // Start latency, start while busy, stray pulse, forward step, reset mid-WAIT.
    start = 1'b1;                                   // sampled at the next edge (N)
    tick();
    start = 1'b0;
    check("lat_clear_n1", 32'(tiles_clear), 32'd1);
    check("lat_busy_n1",  32'(busy),        32'd1);
    tick();
    check("lat_settle_clear", 32'(tiles_clear), 32'd0);
    check("lat_settle_turn",  32'(tile_myturn), 32'd0);
    tick();
    check("lat_grant_n3",   32'(tile_myturn), 32'b0001);
    check("lat_turns_pre",  32'(turns),       32'd0);
    tick();
    check("wait_turn_low",  32'(tile_myturn), 32'd0);
    check("wait_turns_one", 32'(turns),       32'd1);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("busy_start_no_clear", 32'(tiles_clear), 32'd0);
      check("busy_start_busy",     32'(busy),        32'd1);
    end
    start = 1'b0;
    tile_passfwd = 4'b1000;                          // tile 3 while cur_idx = 0
    tick();
    tile_passfwd = '0;
    check("stray_err",  32'(err),         32'd1);
    check("stray_cur",  32'(cur_idx),     32'd0);
    check("stray_turn", 32'(tile_myturn), 32'd0);
    check("stray_state_busy", 32'({busy, done, fail}), 32'b100);
    tile_passfwd = 4'b0001;
    tick();
    tile_passfwd = '0;
    check("fwd_next_grant", 32'(tile_myturn), 32'b0010);
    check("fwd_cur",        32'(cur_idx),     32'd1);
    tick();
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    tick();
    reset = 1'b1;
    repeat (2) tick();
    check("post_reset_no_clear", 32'(tiles_clear), 32'd0);
    check("post_reset_no_turn",  32'(tile_myturn), 32'd0);
    check("post_reset_idle",     32'(busy),        32'd0);

    // Table of whole solves.
    for (int v = 0; v < 6; v++) begin
      cfg_bak    = vecs[v].bak_first;
      cfg_both   = vecs[v].both_first;
      cfg_silent = vecs[v].silent;
      for (int i = 0; i < NT; i++) grant_cnt[i] = 0;
      pend = 0;
      exp_q.delete();
      o = vecs[v].order;
      for (int i = 0; i < vecs[v].n_grants; i++) exp_q.push_back(o[2*i +: 2]);
      clear_cnt = 0;
      stub_en = 1'b1;

      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_clear", 32'(tiles_clear), 32'd1);
      check("start_err",   32'(err),         32'd0);
      check("start_fail",  32'(fail),        32'd0);
      check("start_done",  32'(done),        32'd0);
      check("start_turns", 32'(turns),       32'd0);

      for (int c = 0; c < 300; c++) begin
        if (done || fail) break;
        tick();
      end
      end_cyc = cyc;
      check("end_reached", 32'(done | fail), 32'd1);
      check("end_done",    32'(done),    32'(vecs[v].exp_done));
      check("end_fail",    32'(fail),    32'(vecs[v].exp_fail));
      check("end_err",     32'(err),     32'(vecs[v].exp_err));
      check("end_turns",   32'(turns),   32'(vecs[v].exp_turns));
      check("end_cur",     32'(cur_idx), 32'(vecs[v].exp_cur));
      check("end_busy",    32'(busy),    32'd0);
      check("end_grants_left", 32'(exp_q.size()), 32'd0);
      if (vecs[v].silent >= 0)
        check("watchdog_latency", 32'(end_cyc - last_grant_cyc), 32'(WL + 1));
      else
        check("pulse_to_end_latency", 32'(end_cyc - last_pulse_cyc), 32'd1);
      tick();
      check("one_clear_pulse", 32'(clear_cnt), 32'd1);
      check("end_level_held",  32'({done, fail}), 32'({vecs[v].exp_done, vecs[v].exp_fail}));
      stub_en = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_sequencer.md
# tile_sequencer

Turn scheduler for the brute-force solver: owns the tile chain and decides which tile holds control. It clears all tiles, grants a one-cycle turn pulse to one tile at a time, and steps forward on that tile's pass-forward pulse or back on its pass-back pulse. It reports solved or unsolvable, and keeps a turn counter and a sticky protocol-error flag. It sits between top-level control and the array of tile instances.

## Interface
- NUM_TILES, 16, number of tiles in the chain (GRID_LEN²); must be ≥2.
- WAIT_LIMIT, 64, maximum cycles in WAIT before watchdog trip; 0 disables the watchdog.
- IW, $clog2(NUM_TILES), width of the tile index.
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a solve; sampled only in IDLE, DONE, FAIL.
- tile_passfwd  in  NUM_TILES  per-tile one-cycle "value found" pulse.
- tile_passbak  in  NUM_TILES  per-tile one-cycle "nothing works" pulse.
- tiles_clear  out  1  synchronous clear to all tiles (drives their reset).
- tile_myturn  out  NUM_TILES  one-hot, one-cycle turn grant.
- cur_idx  out  IW  index of the tile currently holding control.
- busy  out  1  high in every state except IDLE, DONE, FAIL.
- done  out  1  level; grid solved.
- fail  out  1  level; search exhausted, or watchdog tripped.
- err  out  1  sticky protocol error; cleared only by reset or start.
- turns  out  16  grants issued since start; saturates at 16'hFFFF.

## Operation
- States: IDLE, CLEAR, SETTLE, GRANT, WAIT, DONE, FAIL.
- IDLE / DONE / FAIL + start → CLEAR. On this transition: cur_idx←0, turns←0, err←0, watchdog←0.
- CLEAR: tiles_clear=1. Next state is SETTLE.
  - SETTLE exists because tiles spend one cycle in their reset state before they wait.
- SETTLE: no outputs. Next state is GRANT.
- GRANT: tile_myturn[cur_idx]=1 for exactly this cycle; turns increments (saturating). Next state is WAIT.
- WAIT: watches only the bits at cur_idx; the watchdog counts WAIT cycles.
  - passfwd only, cur_idx<NUM_TILES-1: cur_idx+1, → GRANT.
  - passfwd only, cur_idx=NUM_TILES-1: → DONE.
  - passbak only, cur_idx>0: cur_idx-1, → GRANT. The re-granted tile resumes its own search from its next candidate.
  - passbak only, cur_idx=0: → FAIL.
  - Both bits set at the same time: err←1, handled as passbak.
  - Watchdog reaches WAIT_LIMIT (when WAIT_LIMIT≠0): err←1, → FAIL.
- Any pass bit asserted at an index ≠ cur_idx, in any state: err←1 and the pulse is otherwise ignored. Pass bits are ignored entirely in CLEAR and SETTLE, and raise no err there.
- start is ignored while busy.
- done is high only in DONE; fail is high only in FAIL.
- cur_idx holds its last value in DONE and FAIL, so it can be used for debug.
- Index arithmetic never wraps: the end cases are captured by DONE and FAIL before the index would leave the range.

## Timing
- Reset (reset=0, asynchronous) puts the block in IDLE with every output 0 (tile_myturn=0, tiles_clear=0, cur_idx=0, turns=0, err=0, busy=0, done=0, fail=0).
- Reset deassertion is synchronised by the integrator; the block takes no action until the first start.
- Reset asserted mid-solve aborts immediately; no further grant or clear is issued.
- All outputs are registered, Moore-style.
- Latencies:
  - start high at edge N: tiles_clear in cycle N+1, then SETTLE, then the first grant in cycle N+3.
  - A pass pulse sampled at edge M in WAIT gives the next grant in cycle M+1, or done/fail high in cycle M+1.
- Minimum grant-to-grant spacing is 2 cycles plus the tile's response time.
- At most one tile_myturn bit is ever high, and it is never high for two consecutive cycles.

## Test plan
- NUM_TILES=4, stub tiles return passfwd 4 cycles after each grant → grants to tiles 0,1,2,3 in order; done=1; turns=4; err=0; fail=0.
- Tile 2 returns passbak on its first turn and passfwd afterwards, all others return passfwd → grant order 0,1,2,1,2,3; done=1; turns=6.
- Tile 0 returns passbak on its first grant → fail=1 one cycle after the pulse; turns=1; cur_idx=0.
- Tile 1 returns passfwd and passbak in the same cycle → err=1, next grant goes to tile 0. Separately, a passfwd from tile 3 while cur_idx=0 → err=1 and no state change.
- WAIT_LIMIT=8, tile never responds → fail=1 and err=1 after 8 WAIT cycles. A following start clears err and fail, turns=0, and tiles_clear pulses once.
- reset pulled low mid-WAIT → all outputs 0 immediately. start during busy → ignored, with no extra tiles_clear.
